shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one DATA_W-wide D-flip-flop storage register between NUM_REQ requesters. A requester raises `req`, waits for its one-hot `gnt`, and then owns the register. The register samples the owner's `wdata` on every granted cycle, until the owner drops `req` or its hold budget runs out. The block sits in front of the flip-flop datapath and is its sole writer.

## Interface
- NUM_REQ, 4, number of requesters (1–8)
- DATA_W, 8, width of shared register and each write-data lane
- MAX_HOLD, 4, maximum consecutive granted cycles per ownership (≥1)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  NUM_REQ  per-requester request level; must stay high until gnt seen
- wdata  input  NUM_REQ*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot ownership, registered
- ack  output  NUM_REQ  one-cycle pulse to the owner after release
- q  output  DATA_W  shared register contents
- owner  output  max(1,$clog2(NUM_REQ))  index of current or last owner
- busy  output  1  high while in HOLD

## Operation
- FSM states: IDLE, HOLD.
- **IDLE:**
  - If any req, select winner i = first set bit searching from ptr upward with wrap.
  - At the edge: gnt[i]=1, q<=wdata lane i, owner=i, hold_cnt=MAX_HOLD-1, go to HOLD.
  - If no req, stay in IDLE with q unchanged.
- **HOLD:** each edge, q<=wdata lane owner.
- **Release condition:** req[owner]==0 or hold_cnt==0.
- **On release edge:**
  - gnt cleared, state IDLE, ptr=(owner+1) mod NUM_REQ.
  - ack[owner]=1 for exactly the next cycle.
  - q not written on a release edge caused by req drop.
  - q is written on a release edge caused by budget expiry.
  - If not releasing, hold_cnt decrements.
- Non-owner req during HOLD is ignored and stays pending. There is no pre-emption.
- Req drop and budget expiry in the same cycle produce a single release and a single ack.
- After release, IDLE lasts at least one cycle (dead cycle) before the next gnt.
- The same requester re-requesting immediately loses to any other pending requester, because ptr has advanced past it.
- NUM_REQ=1: ptr is constant 0. Behaviour is otherwise identical.

## Timing
- **Reset values:** gnt=0, ack=0, q=0, owner=0, busy=0, ptr=0, state IDLE, hold_cnt=0.
- **Grant latency:** req sampled high in IDLE in cycle N → gnt and q valid in cycle N+1.
- **Max ownership:** MAX_HOLD cycles of gnt high. Worst-case wait for any requester: (NUM_REQ-1)*(MAX_HOLD+1)+1 cycles.
- **Ack:** one cycle, coincident with the first IDLE cycle after release.
- **Reset asserted mid-HOLD:** gnt, ack and q clear asynchronously. No ack is issued for the aborted ownership. After reset deasserts, arbitration restarts from ptr=0.

## Configuration
- Macro: SHARED_REG_ARB_FIXED_PRIO_EN.
- **Defined:** fixed priority, lowest asserted index always wins. ptr is unused and held at 0.
- **Undefined (default):** round-robin via ptr as described above.
- All other behaviour (hold budget, ack, dead cycle) is identical in both modes.

## Structure
- Package shared_reg_pkg holds:
  - state enum (IDLE, HOLD)
  - function next_winner(req, ptr) returning index and valid
  - localparam for owner width
- Sub-module dff_reg:
  - DATA_W-wide register, async active-high reset to 0, with write enable.
  - Instantiated once as the shared storage; the arbiter drives its enable and mux-selected D input.

## Test plan
Common setup: NUM_REQ=4, DATA_W=8, MAX_HOLD=4.
1. **Reset:** reset=1 with req=4'b1111 → all outputs 0. After release, the first edge with req=4'b0101 gives gnt=4'b0001 and q=lane0.
2. **Single owner, early drop:** req[2]=1 for 2 cycles with lane2=8'hA5 → gnt[2] high 2 cycles, q=8'hA5, ack[2] pulses once, busy falls.
3. **Budget expiry and rotation:** req=4'b1011 held constantly →
   - grants in order 0,1,3,0, each 4 cycles long, separated by 1 dead cycle.
   - one ack per ownership.
4. **Simultaneous release:** owner drops req on its 4th granted cycle → exactly one ack, no double release, and the next winner is granted after one dead cycle.
5. **Reset mid-HOLD:** assert reset on the 2nd granted cycle of requester 1 → gnt=0 and q=8'h00 immediately, no ack. After release with req=4'b0010, gnt[1] is reissued.
6. **Fixed-priority build (macro defined):** req=4'b1011 held → requester 0 wins every arbitration and requesters 1 and 3 starve. ack[0] pulses every 5 cycles.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for shared_reg_arbiter: FSM state, winner search and
// owner-index sizing.
package shared_reg_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } winner_t;

    function automatic int unsigned owner_width(int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // First set request at or after ptr, wrapping within the num_req live lanes.
    function automatic winner_t next_winner(logic [MAX_REQ-1:0] req, logic [IDX_W-1:0] ptr,
                                            int unsigned num_req);
        winner_t          win;
        logic [IDX_W-1:0] idx;
        win = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = IDX_W'((32'(ptr) + k) % num_req);
            if (!win.valid && (k < num_req) && req[idx]) begin
                win.valid = 1'b1;
                win.idx   = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dff_reg.sv
// Plain D-flip-flop register with write enable and asynchronous active-high
// clear; used as the storage shared between all requesters.
module dff_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Arbiter granting one requester at a time write ownership of a shared register.
// Round-robin by default; define SHARED_REG_ARB_FIXED_PRIO_EN for lowest-index-wins.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DATA_W-1:0]        wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               ack,
    output logic [DATA_W-1:0]                q,
    output logic [owner_width(NUM_REQ)-1:0]  owner,
    output logic                             busy
);

    localparam int unsigned OWNER_W = owner_width(NUM_REQ);
    localparam int unsigned HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    winner_t             win;
    logic [OWNER_W-1:0]  win_idx;
    logic [OWNER_W-1:0]  next_ptr;
    logic [OWNER_W-1:0]  sel;
    logic                owner_req;
    logic                rel;
    logic                reg_we;
    logic [DATA_W-1:0]   reg_d;

    assign win       = next_winner(MAX_REQ'(req), IDX_W'(ptr_q), NUM_REQ);
    assign win_idx   = OWNER_W'(win.idx);
    // gnt_q is one-hot on the owner while holding, so this is req[owner].
    assign owner_req = |(req & gnt_q);
    assign rel       = !owner_req || (hold_cnt_q == '0);

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win.valid) begin
                    state_d    = StHold;
                    gnt_d      = NUM_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    hold_cnt_d = HOLD_W'(MAX_HOLD - 1);
                end
            end
            StHold: begin
                if (rel) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ack_d   = gnt_q;
                    ptr_d   = next_ptr;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: ;
        endcase
    end

    // A release caused by a dropped request must not capture that lane.
    always_comb begin
        busy   = (state_q == StHold);
        gnt    = gnt_q;
        ack    = ack_q;
        owner  = owner_q;
        sel    = owner_q;
        reg_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel    = win_idx;
                reg_we = win.valid;
            end
            StHold: reg_we = owner_req;
            default: ;
        endcase
        reg_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == OWNER_W'(i)) begin
                reg_d = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    dff_reg #(
        .DATA_W(DATA_W)
    ) u_shared_reg (
        .clk  (clk),
        .reset(reset),
        .en   (reg_we),
        .d    (reg_d),
        .q    (q)
    );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: a cycle model of the arbitration
// rules compared every cycle, plus directed literal checks.
module tb_shared_reg_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;
    localparam logic [31:0] LANES = 32'h33A5_2211;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [31:0] wdata = LANES;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .wdata(wdata),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .owner(owner),
        .busy (busy)
    );

    typedef struct packed {
        logic       busy;
        logic [7:0] owner;
        logic [7:0] ptr;
        logic [7:0] used;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic [7:0] q;
    } model_t;

    model_t m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership counted upward in granted cycles; release at the budget or on a drop.
    function automatic model_t model_step(model_t s, logic [3:0] r, logic [31:0] wd);
        model_t n;
        logic   found;
        int     c;
        int     o;
        n     = s;
        n.ack = '0;
        found = 1'b0;
        o     = int'(s.owner);
        if (!s.busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (int'(s.ptr) + k) % NUM_REQ;
                if (!found && r[c]) begin
                    found  = 1'b1;
                    n.busy = 1'b1;
                    n.owner = 8'(c);
                    n.used = 8'd1;
                    n.gnt  = 4'(1 << c);
                    n.q    = wd[c*8 +: 8];
                end
            end
        end else begin
            if (r[o]) n.q = wd[o*8 +: 8];
            if (!r[o] || int'(s.used) == MAX_HOLD) begin
                n.busy = 1'b0;
                n.gnt  = '0;
                n.ack  = 4'(1 << o);
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
                n.ptr  = 8'd0;
`else
                n.ptr  = 8'((o + 1) % NUM_REQ);
`endif
            end else begin
                n.used = s.used + 8'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_step(m, req, wdata);
    end

    always @(negedge clk) begin
        check("model_gnt",   32'(gnt),   32'(m.gnt));
        check("model_ack",   32'(ack),   32'(m.ack));
        check("model_q",     32'(q),     32'(m.q));
        check("model_owner", 32'(owner), 32'(m.owner));
        check("model_busy",  32'(busy),  32'(m.busy));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int order[$];
    int exp_order[4];
    int ack_cnt;
    int hi_cnt;
    logic [3:0] prev_gnt;

    initial begin
        // 1: reset with all requests high, then first arbitration from ptr 0
        req = 4'b1111;
        tick();
        tick();
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_ack",   32'(ack),   32'h0);
        check("rst_q",     32'(q),     32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        req   = 4'b0101;
        reset = 1'b0;
        tick();
        check("t1_gnt",  32'(gnt),  32'h1);
        check("t1_q",    32'(q),    32'h11);
        check("t1_busy", 32'(busy), 32'h1);
        req          = 4'b0000;
        wdata[7:0]   = 8'h77;
        tick();
        check("t1_ack",    32'(ack), 32'h1);
        check("t1_q_kept", 32'(q),   32'h11);
        wdata = LANES;
        tick();
        check("t1_ack_clr", 32'(ack), 32'h0);

        // 2: single owner holding two cycles then dropping
        req = 4'b0100;
        tick();
        check("t2_gnt_a", 32'(gnt), 32'h4);
        check("t2_q",     32'(q),   32'hA5);
        tick();
        check("t2_gnt_b", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("t2_ack",  32'(ack),  32'h4);
        check("t2_busy", 32'(busy), 32'h0);
        check("t2_gnt0", 32'(gnt),  32'h0);
        check("t2_q2",   32'(q),    32'hA5);
        tick();
        check("t2_ack_clr", 32'(ack), 32'h0);

        // 3: budget expiry with constant requests
        reset_pulse();
        req      = 4'b1011;
        ack_cnt  = 0;
        hi_cnt   = 0;
        prev_gnt = 4'b0000;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (gnt != 4'b0000) hi_cnt++;
            if (ack != 4'b0000) ack_cnt++;
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) order.push_back(i);
            end
            prev_gnt = gnt;
        end
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 3, 0};
`endif
        check("t3_grants", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_order", 32'(order[i]), 32'(exp_order[i]));
        check("t3_acks",     32'(ack_cnt), 32'd4);
        check("t3_hi_cycles", 32'(hi_cnt), 32'd16);
        req = 4'b0000;
        tick();
        tick();

        // 4: owner drops on its final budgeted cycle
        reset_pulse();
        req = 4'b0011;
        for (int t = 0; t < 4; t++) tick();
        check("t4_gnt_4th", 32'(gnt), 32'h1);
        req        = 4'b0010;
        wdata[7:0] = 8'h5A;
        tick();
        check("t4_ack",  32'(ack), 32'h1);
        check("t4_gnt0", 32'(gnt), 32'h0);
        check("t4_q",    32'(q),   32'h11);
        wdata = LANES;
        tick();
        check("t4_ack_once", 32'(ack), 32'h0);
        check("t4_next_gnt", 32'(gnt), 32'h2);
        check("t4_next_q",   32'(q),   32'h22);
        req = 4'b0000;
        tick();
        tick();

        // 5: reset during requester 1's second granted cycle
        reset_pulse();
        req = 4'b0010;
        tick();
        tick();
        check("t5_gnt_pre", 32'(gnt), 32'h2);
        reset = 1'b1;
        #1;
        check("t5_gnt_rst",  32'(gnt),  32'h0);
        check("t5_q_rst",    32'(q),    32'h0);
        check("t5_ack_rst",  32'(ack),  32'h0);
        check("t5_busy_rst", 32'(busy), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_regnt", 32'(gnt), 32'h2);
        check("t5_no_ack", 32'(ack), 32'h0);
        check("t5_q",     32'(q),   32'h22);
        req = 4'b0000;
        for (int t = 0; t < 5; t++) tick();

`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
        // 6: fixed priority starves higher indices
        reset_pulse();
        req      = 4'b1011;
        prev_gnt = 4'b0000;
        ack_cnt  = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            prev_gnt = prev_gnt | gnt;
            if (ack != 4'b0000) begin
                ack_cnt++;
                check("t6_ack_lane",   32'(ack), 32'h1);
                check("t6_ack_period", 32'(t),   32'(5 * ack_cnt));
            end
        end
        check("t6_gnt_union", 32'(prev_gnt), 32'h1);
        check("t6_acks",      32'(ack_cnt),  32'd3);
        req = 4'b0000;
        tick();
        tick();
`endif

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
